apb_master_mux: RTL and testbench

Parametrised APB4 master for the AXI4-Lite-to-APB bridge. It replaces the single-select master with a multi-slave master. It accepts one transfer at a time from the bridge front end over a valid/ready request channel, decodes the target slave from the address, and drives a one-hot PSEL vector through SETUP and ACCESS phases. It muxes the selected slave's PREADY/PRDATA/PSLVERR and returns a registered response over a valid/ready response channel.

---
 rtl/apb_master_pkg.sv | 25 ++
 rtl/apb_master_mux_if.sv | 63 ++++++
 rtl/apb_addr_decode.sv | 32 +++
 rtl/apb_master_mux.sv | 187 ++++++++++++++++++
 tb/tb_apb_master_mux.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_pkg
// Shared definitions for the multi-slave APB4 master:
//   - apb_state_e : transfer state machine encoding (IDLE, SETUP, ACCESS, RESP)
//   - APB_PROT_W  : width of the APB protection field
//   - sel_width() : width of the slave-index field, max(1, clog2(NUM_SLAVES))
// -----------------------------------------------------------------------------
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_PROT_W = 3;

    // A single slave still needs a 1-bit index field so the decoder has
    // something to compare against.
    function automatic int sel_width(input int num_slaves);
        return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
    endfunction

endpackage

// File: rtl/apb_master_mux_if.sv
// -----------------------------------------------------------------------------
// apb_master_mux_if
// Bundles the request channel, response channel and the APB4 bus of the
// multi-slave master.
//   master modport : view of apb_master_mux (drives PSEL/PENABLE/..., req_ready,
//                    rsp_*; receives req_*, rsp_ready, PREADY/PRDATA/PSLVERR)
//   slave modport  : the opposite view (bridge front end + APB slaves)
// Parameters: ADDR_W, DATA_W, NUM_SLAVES (must match the master instance).
// -----------------------------------------------------------------------------
interface apb_master_mux_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
) ();

    // request channel
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDR_W-1:0]        req_addr;
    logic [DATA_W-1:0]        req_wdata;
    logic [DATA_W/8-1:0]      req_strb;
    logic [APB_PROT_W-1:0]    req_prot;

    // response channel
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;

    // APB4 bus
    logic [ADDR_W-1:0]        PADDR;
    logic [APB_PROT_W-1:0]    PPROT;
    logic [NUM_SLAVES-1:0]    PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [DATA_W-1:0]        PWDATA;
    logic [DATA_W/8-1:0]      PSTRB;
    logic [NUM_SLAVES-1:0]    PREADY;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]    PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );

endinterface

// File: rtl/apb_addr_decode.sv
// -----------------------------------------------------------------------------
// apb_addr_decode
// Combinational address decoder: extracts the slave index from
// i_addr[SEL_LSB +: SEL_W] and flags whether it names an existing slave.
//   i_addr  in  ADDR_W  byte address
//   o_idx   out SEL_W   slave index field
//   o_valid out 1       index < NUM_SLAVES
// -----------------------------------------------------------------------------
module apb_addr_decode
    import apb_master_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [SEL_W-1:0]  o_idx,
    output logic              o_valid
);

    // One extra bit so NUM_SLAVES == 2**SEL_W is representable.
    localparam logic [SEL_W:0] NUM_SLAVES_EXT = (SEL_W+1)'(NUM_SLAVES);

    // Only the index field matters; the rest of the address is intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^i_addr;

    assign o_idx   = i_addr[SEL_LSB +: SEL_W];
    assign o_valid = ({1'b0, o_idx} < NUM_SLAVES_EXT);

endmodule

// File: rtl/apb_master_mux.sv
// -----------------------------------------------------------------------------
// apb_master_mux
// Multi-slave APB4 master. Accepts one transfer at a time on the request
// channel, decodes the target slave from the address, runs SETUP/ACCESS on a
// one-hot PSEL vector and returns a registered response.
//   PCLK    in  clock
//   PRESET  in  asynchronous active-high reset
//   bus     apb_master_mux_if.master (request, response and APB4 signals)
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles without PREADY (response then carries rsp_err=1).
// -----------------------------------------------------------------------------
module apb_master_mux
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_master_mux_if.master  bus
);

    localparam int SEL_W  = sel_width(NUM_SLAVES);
    localparam int STRB_W = DATA_W / 8;
    localparam int PAD_N  = 1 << SEL_W;

    apb_state_e              r_state;
    apb_state_e              w_state_next;

    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [APB_PROT_W-1:0]   r_prot;
    logic                    r_write;
    logic [SEL_W-1:0]        r_idx;
    logic [DATA_W-1:0]       r_rsp_rdata;
    logic                    r_rsp_err;

    logic [SEL_W-1:0]        w_dec_idx;
    logic                    w_dec_valid;
    logic                    w_accept;
    logic                    w_sel_ready;
    logic                    w_timeout_hit;
    logic                    w_apb_active;
    logic [NUM_SLAVES-1:0]   w_psel;

    // Slave inputs padded to a power of two so r_idx never indexes out of range.
    logic [PAD_N-1:0]        w_pready_ext;
    logic [PAD_N-1:0]        w_pslverr_ext;
    logic [DATA_W-1:0]       w_prdata_ext [PAD_N];

    apb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB),
        .SEL_W      (SEL_W)
    ) u_decode (
        .i_addr  (bus.req_addr),
        .o_idx   (w_dec_idx),
        .o_valid (w_dec_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < PAD_N; gi++) begin : g_pad
            if (gi < NUM_SLAVES) begin : g_slave
                assign w_pready_ext[gi]  = bus.PREADY[gi];
                assign w_pslverr_ext[gi] = bus.PSLVERR[gi];
                assign w_prdata_ext[gi]  = bus.PRDATA[gi*DATA_W +: DATA_W];
            end else begin : g_empty
                assign w_pready_ext[gi]  = 1'b0;
                assign w_pslverr_ext[gi] = 1'b0;
                assign w_prdata_ext[gi]  = '0;
            end
        end
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
            assign w_psel[gi] = w_apb_active & (r_idx == SEL_W'(gi));
        end
    endgenerate

    assign w_accept     = bus.req_valid & bus.req_ready;
    assign w_sel_ready  = w_pready_ext[r_idx];
    assign w_apb_active = (r_state == SETUP) || (r_state == ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W   = (TMO_RAW < 8) ? 8 : ((TMO_RAW > 16) ? 16 : TMO_RAW);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts ACCESS cycles without PREADY; cleared while in SETUP so it
    // starts at zero on the first ACCESS cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_sel_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Expiry on the cycle whose increment would reach TIMEOUT_CYCLES;
    // a simultaneous PREADY takes priority in the FSM.
    assign w_timeout_hit = (r_state == ACCESS) && !w_sel_ready &&
                           (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = w_dec_valid ? SETUP : RESP;
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                if (w_sel_ready || w_timeout_hit) w_state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (w_accept) w_state_next = w_dec_valid ? SETUP : RESP;
                    else          w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_prot      <= '0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_strb  <= bus.req_write ? bus.req_strb : '0;
                r_prot  <= bus.req_prot;
                r_write <= bus.req_write;
                r_idx   <= w_dec_idx;
                // Decode errors skip the APB phases, so the response is set here.
                if (!w_dec_valid) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end
            if (r_state == ACCESS) begin
                if (w_sel_ready) begin
                    r_rsp_rdata <= r_write ? '0 : w_prdata_ext[r_idx];
                    r_rsp_err   <= w_pslverr_ext[r_idx];
                end else if (w_timeout_hit) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = (r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    assign bus.PADDR   = r_addr;
    assign bus.PPROT   = r_prot;
    assign bus.PWRITE  = r_write;
    assign bus.PWDATA  = r_wdata;
    assign bus.PSTRB   = r_strb;
    assign bus.PSEL    = w_psel;
    assign bus.PENABLE = (r_state == ACCESS);

endmodule

// File: tb/tb_apb_master_mux.sv
// -----------------------------------------------------------------------------
// tb_apb_master_mux
// Self-checking bench for apb_master_mux with 5 slaves (3-bit index field, so
// index values 5..7 exercise decode errors). A behavioural APB slave responds
// with a configurable wait count; unselected slaves drive random noise.
// -----------------------------------------------------------------------------
module tb_apb_master_mux;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 5;
    localparam int TMO = 8;

    logic PCLK;
    logic PRESET;

    int n_tests = 0;
    int n_fail  = 0;

    apb_master_mux_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) bus ();

    apb_master_mux #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- behavioural APB slaves ----------------
    int          sl_wait  = 0;
    logic [31:0] sl_rdata = '0;
    logic        sl_err   = 1'b0;
    int          wcnt     = 0;

    always @(negedge PCLK) begin
        for (int s = 0; s < NS; s++) begin
            bus.PREADY[s]            = 1'($urandom_range(0, 1));
            bus.PSLVERR[s]           = 1'($urandom_range(0, 1));
            bus.PRDATA[s*DW +: DW]   = $urandom;
        end
        if (bus.PENABLE) begin
            for (int s = 0; s < NS; s++) begin
                if (bus.PSEL[s]) begin
                    if (wcnt >= sl_wait) begin
                        bus.PREADY[s]          = 1'b1;
                        bus.PRDATA[s*DW +: DW] = sl_rdata;
                        bus.PSLVERR[s]         = sl_err;
                    end else begin
                        bus.PREADY[s] = 1'b0;
                        wcnt++;
                    end
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic wr, input logic [31:0] addr, input int wait_n,
                                  input logic [31:0] rd, input logic serr,
                                  output int idx, output logic dec_err, output int acc,
                                  output logic [31:0] exp_rd, output logic exp_err);
        idx     = int'((addr >> 12) & 32'h7);
        dec_err = (idx >= NS);
        if (dec_err) begin
            acc = 0; exp_rd = 0; exp_err = 1'b1;
        end else begin
            acc = wait_n + 1; exp_rd = wr ? 32'h0 : rd; exp_err = serr;
`ifdef APB_MASTER_TIMEOUT_EN
            if (wait_n >= TMO) begin
                acc = TMO; exp_rd = 0; exp_err = 1'b1;
            end
`endif
        end
    endfunction

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] prot);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        bus.req_prot  = prot;
    endtask

    // Called with a request already presented in the cycle of its acceptance.
    // Follows it through SETUP/ACCESS into RESP, then holds rsp_ready low.
    task automatic follow(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input int idx, input logic dec_err, input int acc,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int hold, input string name);
        logic [NS-1:0] exp_psel;
        logic [71:0]   exp_apb;
        logic [71:0]   got_apb;
        exp_psel = dec_err ? '0 : (NS'(1) << idx);
        exp_apb  = {addr, wr, wdata, (wr ? strb : 4'h0), prot};
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: req_ready=%b required 1", name, bus.req_ready);
        end
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        if (!dec_err) begin
            n_tests++;
            got_apb = {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB, bus.PPROT};
            if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== {exp_psel, 1'b0, 1'b0} || got_apb !== exp_apb) begin
                n_fail++;
                $display("FAIL %s setup: psel=%b en=%b rv=%b apb=%h required psel=%b en=0 rv=0 apb=%h",
                         name, bus.PSEL, bus.PENABLE, bus.rsp_valid, got_apb, exp_psel, exp_apb);
            end
            for (int c = 0; c < acc; c++) begin
                @(negedge PCLK);
                #1;
                n_tests++;
                got_apb = {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB, bus.PPROT};
                if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== {exp_psel, 1'b1, 1'b0} || got_apb !== exp_apb) begin
                    n_fail++;
                    $display("FAIL %s access%0d: psel=%b en=%b rv=%b apb=%h required psel=%b en=1 rv=0 apb=%h",
                             name, c, bus.PSEL, bus.PENABLE, bus.rsp_valid, got_apb, exp_psel, exp_apb);
                end
            end
            @(negedge PCLK);
            #1;
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(negedge PCLK);
                #1;
            end
            n_tests++;
            if ({bus.rsp_valid, bus.PSEL, bus.PENABLE, bus.req_ready} !== {1'b1, {NS{1'b0}}, 1'b0, 1'b0} ||
                bus.rsp_rdata !== exp_rd || bus.rsp_err !== exp_err) begin
                n_fail++;
                $display("FAIL %s resp%0d: rv=%b psel=%b en=%b rr=%b rdata=%h err=%b required rv=1 psel=0 en=0 rr=0 rdata=%h err=%b",
                         name, h, bus.rsp_valid, bus.PSEL, bus.PENABLE, bus.req_ready,
                         bus.rsp_rdata, bus.rsp_err, exp_rd, exp_err);
            end
        end
    endtask

    task automatic release_rsp(input string name);
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: rv=%b rr=%b required rv=0 rr=1", name, bus.rsp_valid, bus.req_ready);
        end
    endtask

    // Full transfer from IDLE: present, follow, release.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                        input logic [31:0] rd, input logic serr, input int hold, input string name);
        int idx; logic dec; int acc; logic [31:0] erd; logic eerr;
        model(wr, addr, wait_n, rd, serr, idx, dec, acc, erd, eerr);
        @(negedge PCLK);
        sl_wait = wait_n; sl_rdata = rd; sl_err = serr;
        drive_req(wr, addr, wdata, strb, prot);
        follow(wr, addr, wdata, strb, prot, idx, dec, acc, erd, eerr, hold, name);
        release_rsp(name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        PRESET = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_strb = '0; bus.req_prot = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        n_tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB, bus.PPROT,
             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: psel=%b en=%b paddr=%h rv=%b rdata=%h err=%b rr=%b required all 0, rr=1",
                     bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h0, 1'b0, 0, "write_slave1");
    endtask

    task automatic test_read_wait();
        xfer(1'b0, 32'h0000_2000, 32'hA5A5_0F0F, 4'hC, 3'b001, 3, 32'h1234_5678, 1'b0, 0, "read_slave2_ws3");
    endtask

    task automatic test_decode_error();
        xfer(1'b0, 32'h0000_7000, 32'h1111_2222, 4'h3, 3'b000, 0, 32'hCAFE_F00D, 1'b0, 0, "decode_err_7000");
        xfer(1'b1, 32'h0000_5000, 32'h3333_4444, 4'hF, 3'b111, 0, 32'h0, 1'b0, 1, "decode_err_5000");
    endtask

    task automatic test_back_to_back();
        int idx; logic dec; int acc; logic [31:0] erd; logic eerr;
        // slave error on a write, response held for 5 extra cycles
        model(1'b1, 32'h0000_0010, 1, 32'h0, 1'b1, idx, dec, acc, erd, eerr);
        @(negedge PCLK);
        sl_wait = 1; sl_rdata = 32'h0; sl_err = 1'b1;
        drive_req(1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 4'h5, 3'b100);
        follow(1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 4'h5, 3'b100, idx, dec, acc, erd, eerr, 5, "slverr_hold");
        // queued request accepted in the same cycle the response is consumed
        model(1'b0, 32'h0000_1020, 0, 32'h5555_AAAA, 1'b0, idx, dec, acc, erd, eerr);
        sl_wait = 0; sl_rdata = 32'h5555_AAAA; sl_err = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 32'h0000_1020, 32'h0, 4'hF, 3'b000);
        follow(1'b0, 32'h0000_1020, 32'h0, 4'hF, 3'b000, idx, dec, acc, erd, eerr, 0, "chained_read");
        release_rsp("chained_read");
    endtask

    task automatic test_reset_mid_access();
        @(negedge PCLK);
        sl_wait = 50; sl_rdata = 32'h0; sl_err = 1'b0;
        drive_req(1'b1, 32'h0000_3008, 32'h7777_8888, 4'hF, 3'b011);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        @(negedge PCLK);
        #1;
        n_tests++;
        if (bus.PENABLE !== 1'b1 || bus.PSEL !== 5'b01000) begin
            n_fail++;
            $display("FAIL mid_reset pre: en=%b psel=%b required en=1 psel=01000", bus.PENABLE, bus.PSEL);
        end
        PRESET = 1'b1;
        #1;
        n_tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB, bus.PPROT,
             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: psel=%b en=%b paddr=%h rv=%b rr=%b required all 0, rr=1",
                     bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid, bus.req_ready);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        xfer(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000, 0, 32'h0123_4567, 1'b0, 0, "after_reset");
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        xfer(1'b0, 32'h0000_4000, 32'h0, 4'hF, 3'b000, 1000, 32'hFFFF_FFFF, 1'b0, 0, "timeout_abort");
        xfer(1'b0, 32'h0000_1000, 32'h0, 4'hF, 3'b000, TMO - 1, 32'h2468_ACE0, 1'b0, 0, "ready_at_expiry");
    endtask
`endif

    task automatic test_random();
        int idx; logic dec; int acc; logic [31:0] erd; logic eerr;
        logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;
        int wait_n; logic [31:0] rd; logic serr; int hold;
        logic in_resp;
        in_resp = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wr     = 1'($urandom_range(0, 1));
            addr   = $urandom;
            addr[14:12] = 3'($urandom_range(0, 7));
            wdata  = $urandom;
            strb   = 4'($urandom_range(0, 15));
            prot   = 3'($urandom_range(0, 7));
            wait_n = $urandom_range(0, 4);
`ifdef APB_MASTER_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) wait_n = TMO + 2;
`endif
            rd     = $urandom;
            serr   = wr ? 1'($urandom_range(0, 1)) : 1'b0;
            hold   = $urandom_range(0, 2);
            model(wr, addr, wait_n, rd, serr, idx, dec, acc, erd, eerr);
            if (!in_resp) @(negedge PCLK);
            else bus.rsp_ready = 1'b1;
            sl_wait = wait_n; sl_rdata = rd; sl_err = serr;
            drive_req(wr, addr, wdata, strb, prot);
            follow(wr, addr, wdata, strb, prot, idx, dec, acc, erd, eerr, hold, $sformatf("rand%0d", i));
            in_resp = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                release_rsp($sformatf("rand%0d", i));
                in_resp = 1'b0;
            end
        end
        if (in_resp) release_rsp("rand_last");
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_decode_error();
        test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
